// File: rtl/prim_gate_en_ctrl_pkg.sv
// Shared types and helpers for the gate-enable controller.
//   gate_state_e : controller FSM state, explicit 2-bit encodings
//   cnt_width()  : width of the settle/idle counter for a given pair of cycle counts
package prim_gate_pkg;

  typedef enum logic [1:0] {
    StDisabled = 2'b00,
    StEnSettle = 2'b01,
    StEnabled  = 2'b10,
    StDisWait  = 2'b11
  } gate_state_e;

  // Counter must hold values up to max(a, b); one extra code keeps $clog2 >= 1.
  function automatic int cnt_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/prim_gate_en_ctrl_if.sv
// Request/status bundle between a requester and prim_gate_en_ctrl.
//   req, en_req   : request valid and requested state (1 = enable, 0 = disable)
//   ready         : request accepted when req & ready
//   idle          : downstream datapath quiescent
//   mask          : Width-bit AND-gate operand, all-ones or all-zeros
//   en_status     : current gate state
//   ack           : one-cycle completion pulse
//   busy          : controller is mid-transition
interface prim_gate_en_ctrl_if #(
  parameter int unsigned Width = 1
) ();

  logic             req;
  logic             en_req;
  logic             ready;
  logic             idle;
  logic [Width-1:0] mask;
  logic             en_status;
  logic             ack;
  logic             busy;

  // Requester side.
  modport master (
    output req,
    output en_req,
    output idle,
    input  ready,
    input  mask,
    input  en_status,
    input  ack,
    input  busy
  );

  // Controller side.
  modport slave (
    input  req,
    input  en_req,
    input  idle,
    output ready,
    output mask,
    output en_status,
    output ack,
    output busy
  );

endinterface

// File: rtl/prim_gate_en_ctrl.sv
// Gate-enable controller: produces the mask operand for a 2-input AND gating primitive.
// Enable requests raise the mask SettleCycles after acceptance; disable requests drop it
// once the datapath has been idle for IdleCycles consecutive cycles. Each accepted request
// completes with a one-cycle ack pulse.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   gate_if : slave side of prim_gate_en_ctrl_if (req/en_req/ready/idle/mask/en_status/ack/busy)
module prim_gate_en_ctrl
  import prim_gate_pkg::*;
#(
  parameter int unsigned Width        = 1,
  parameter int unsigned SettleCycles = 2,
  parameter int unsigned IdleCycles   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  prim_gate_en_ctrl_if.slave  gate_if
);

  localparam int CntW = cnt_width(int'(SettleCycles), int'(IdleCycles));

  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] IdleLast   = CntW'(IdleCycles - 1);

  gate_state_e     r_state;
  gate_state_e     w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            r_en;
  logic            w_en_next;
  logic            r_ack;
  logic            w_ack_next;
  logic            w_ready;
  logic            w_busy;
  logic            w_accept;

  assign w_ready  = (r_state == StDisabled) || (r_state == StEnabled);
  assign w_busy   = (r_state == StEnSettle) || (r_state == StDisWait);
  assign w_accept = gate_if.req && w_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_en_next    = r_en;
    w_ack_next   = 1'b0;

    unique case (r_state)
      StDisabled: begin
        if (w_accept) begin
          if (gate_if.en_req) begin
            w_state_next = StEnSettle;
            w_cnt_next   = '0;
          end else begin
            // Already disabled: complete immediately.
            w_ack_next = 1'b1;
          end
        end
      end

      StEnSettle: begin
        if (r_cnt == SettleLast) begin
          w_state_next = StEnabled;
          w_cnt_next   = '0;
          w_en_next    = 1'b1;
          w_ack_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end

      StEnabled: begin
        if (w_accept) begin
          if (!gate_if.en_req) begin
            w_state_next = StDisWait;
            w_cnt_next   = '0;
          end else begin
            // Already enabled: complete immediately.
            w_ack_next = 1'b1;
          end
        end
      end

      StDisWait: begin
        if (!gate_if.idle) begin
          // Idle run must be consecutive; any busy cycle restarts it.
          w_cnt_next = '0;
        end else if (r_cnt == IdleLast) begin
          w_state_next = StDisabled;
          w_cnt_next   = '0;
          w_en_next    = 1'b0;
          w_ack_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end

      default: begin
        w_state_next = StDisabled;
        w_cnt_next   = '0;
        w_en_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StDisabled;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_en    <= w_en_next;
      r_ack   <= w_ack_next;
    end
  end

  // Mask is a pure fan-out of the r_en flop, so it cannot glitch.
  assign gate_if.mask      = {Width{r_en}};
  assign gate_if.en_status = r_en;
  assign gate_if.ack       = r_ack;
  assign gate_if.ready     = w_ready;
  assign gate_if.busy      = w_busy;

  ack_single_pulse_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gate_if.ack |=> !gate_if.ack);

  mask_all_equal_a: assert property (@(posedge clk_i)
    gate_if.mask == {Width{gate_if.mask[0]}});

  ready_not_busy_a: assert property (@(posedge clk_i)
    gate_if.ready == !gate_if.busy);

endmodule

// File: tb/tb_prim_gate_en_ctrl.sv
module tb_prim_gate_en_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  prim_gate_en_ctrl_if #(.Width(1)) a_if ();
  prim_gate_en_ctrl_if #(.Width(8)) b_if ();

  prim_gate_en_ctrl #(
    .Width        (1),
    .SettleCycles (2),
    .IdleCycles   (4)
  ) u_dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .gate_if (a_if)
  );

  prim_gate_en_ctrl #(
    .Width        (8),
    .SettleCycles (1),
    .IdleCycles   (1)
  ) u_dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .gate_if (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic idle_pat [8];

  initial begin
    checks = 0;
    errors = 0;
    idle_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n     = 1'b0;
    a_if.req  = 1'b0; a_if.en_req = 1'b0; a_if.idle = 1'b0;
    b_if.req  = 1'b0; b_if.en_req = 1'b0; b_if.idle = 1'b0;
    tick();
    tick();

    // Reset state
    chk1("rst_mask", a_if.mask[0], 1'b0);
    chk1("rst_status", a_if.en_status, 1'b0);
    chk1("rst_ack", a_if.ack, 1'b0);
    chk1("rst_busy", a_if.busy, 1'b0);
    chk1("rst_ready", a_if.ready, 1'b1);
    chk8("rst_b_mask", b_if.mask, 8'h00);
    rst_n = 1'b1;
    tick();

    // 1. Enable, SettleCycles=2
    a_if.req = 1'b1; a_if.en_req = 1'b1;
    tick();
    a_if.req = 1'b0;
    chk1("en_e0_busy", a_if.busy, 1'b1);
    chk1("en_e0_ready", a_if.ready, 1'b0);
    chk1("en_e0_mask", a_if.mask[0], 1'b0);
    chk1("en_e0_ack", a_if.ack, 1'b0);
    tick();
    chk1("en_e1_mask", a_if.mask[0], 1'b0);
    chk1("en_e1_busy", a_if.busy, 1'b1);
    tick();
    chk1("en_e2_mask", a_if.mask[0], 1'b1);
    chk1("en_e2_ack", a_if.ack, 1'b1);
    chk1("en_e2_status", a_if.en_status, 1'b1);
    chk1("en_e2_ready", a_if.ready, 1'b1);
    tick();
    chk1("en_e3_ack", a_if.ack, 1'b0);

    // 4b. Repeated enable while enabled: no-op ack
    a_if.req = 1'b1; a_if.en_req = 1'b1;
    tick();
    a_if.req = 1'b0;
    chk1("noop_en_ack", a_if.ack, 1'b1);
    chk1("noop_en_mask", a_if.mask[0], 1'b1);
    chk1("noop_en_busy", a_if.busy, 1'b0);
    tick();
    chk1("noop_en_ack_off", a_if.ack, 1'b0);

    // 2. Disable with idle held, IdleCycles=4
    a_if.idle = 1'b1;
    a_if.req = 1'b1; a_if.en_req = 1'b0;
    tick();
    a_if.req = 1'b0;
    chk1("dis_e0_busy", a_if.busy, 1'b1);
    chk1("dis_e0_mask", a_if.mask[0], 1'b1);
    tick();
    chk1("dis_e1_mask", a_if.mask[0], 1'b1);
    tick();
    chk1("dis_e2_mask", a_if.mask[0], 1'b1);
    tick();
    chk1("dis_e3_mask", a_if.mask[0], 1'b1);
    chk1("dis_e3_ack", a_if.ack, 1'b0);
    tick();
    chk1("dis_e4_mask", a_if.mask[0], 1'b0);
    chk1("dis_e4_ack", a_if.ack, 1'b1);
    chk1("dis_e4_ready", a_if.ready, 1'b1);
    tick();
    chk1("dis_e5_ack", a_if.ack, 1'b0);

    // No-op disable while disabled
    a_if.req = 1'b1; a_if.en_req = 1'b0;
    tick();
    a_if.req = 1'b0;
    chk1("noop_dis_ack", a_if.ack, 1'b1);
    chk1("noop_dis_mask", a_if.mask[0], 1'b0);
    tick();
    chk1("noop_dis_ack_off", a_if.ack, 1'b0);

    // 4a. Request during EN_SETTLE is ignored
    a_if.req = 1'b1; a_if.en_req = 1'b1;
    tick();
    a_if.en_req = 1'b0;
    chk1("ign_ready", a_if.ready, 1'b0);
    tick();
    a_if.req = 1'b0;
    chk1("ign_e1_ack", a_if.ack, 1'b0);
    chk1("ign_e1_busy", a_if.busy, 1'b1);
    tick();
    chk1("ign_e2_mask", a_if.mask[0], 1'b1);
    chk1("ign_e2_ack", a_if.ack, 1'b1);
    tick();
    chk1("ign_e3_ack", a_if.ack, 1'b0);
    chk1("ign_e3_busy", a_if.busy, 1'b0);
    tick();
    chk1("ign_e4_mask", a_if.mask[0], 1'b1);
    chk1("ign_e4_ack", a_if.ack, 1'b0);

    // 3. Idle pattern 1,1,1,0,1,1,1,1 in DIS_WAIT
    a_if.idle = 1'b1;
    a_if.req = 1'b1; a_if.en_req = 1'b0;
    tick();
    a_if.req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_if.idle = idle_pat[i];
      tick();
      chk1($sformatf("pat_mask_%0d", i), a_if.mask[0], (i == 7) ? 1'b0 : 1'b1);
      chk1($sformatf("pat_ack_%0d", i), a_if.ack, (i == 7) ? 1'b1 : 1'b0);
    end
    tick();

    // 5. Reset in the middle of DIS_WAIT
    a_if.req = 1'b1; a_if.en_req = 1'b1;
    tick();
    a_if.req = 1'b0;
    tick();
    tick();
    chk1("r5_enabled", a_if.mask[0], 1'b1);
    a_if.idle = 1'b1;
    a_if.req = 1'b1; a_if.en_req = 1'b0;
    tick();
    a_if.req = 1'b0;
    tick();
    chk1("r5_wait_busy", a_if.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1("r5_mask", a_if.mask[0], 1'b0);
    chk1("r5_status", a_if.en_status, 1'b0);
    chk1("r5_ack", a_if.ack, 1'b0);
    chk1("r5_ready", a_if.ready, 1'b1);
    chk1("r5_busy", a_if.busy, 1'b0);
    // Reset wins over a simultaneous request
    a_if.req = 1'b1; a_if.en_req = 1'b1;
    tick();
    a_if.req = 1'b0;
    chk1("r5_req_busy", a_if.busy, 1'b0);
    chk1("r5_req_ack", a_if.ack, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("r5_post_ack", a_if.ack, 1'b0);
    chk1("r5_post_mask", a_if.mask[0], 1'b0);

    // 6. Width=8, SettleCycles=1, IdleCycles=1
    b_if.req = 1'b1; b_if.en_req = 1'b1;
    tick();
    b_if.req = 1'b0;
    chk8("b_en_e0_mask", b_if.mask, 8'h00);
    chk1("b_en_e0_busy", b_if.busy, 1'b1);
    tick();
    chk8("b_en_e1_mask", b_if.mask, 8'hFF);
    chk1("b_en_e1_ack", b_if.ack, 1'b1);
    tick();
    chk1("b_en_e2_ack", b_if.ack, 1'b0);
    b_if.idle = 1'b0;
    b_if.req = 1'b1; b_if.en_req = 1'b0;
    tick();
    b_if.req = 1'b0;
    tick();
    tick();
    chk8("b_dis_busy_mask", b_if.mask, 8'hFF);
    chk1("b_dis_busy_ack", b_if.ack, 1'b0);
    b_if.idle = 1'b1;
    tick();
    chk8("b_dis_mask", b_if.mask, 8'h00);
    chk1("b_dis_ack", b_if.ack, 1'b1);
    chk1("b_dis_ready", b_if.ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
